// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register, used by the RTL and by any user logic.
package usr_pkg;
    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_TGL  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;
endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit: DFF with synchronous reset to a per-bit value, clock enable and q/q_bar outputs.
module usr_bit_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q,
    output logic q_bar
);
    logic r_q;

    always_ff @(posedge clk) begin
        if (reset)
            r_q <= RST_VAL;
        else if (en)
            r_q <= d;
    end

    assign q     = r_q;
    assign q_bar = ~r_q;
endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: load, shift, rotate, toggle and clear, built from per-bit cells.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  q_bar,
    output logic              sout_l,
    output logic              sout_r,
    output logic              zero
);
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_rol;

    // A single-bit register has no interior to slice: shifts take the serial input, rotates hold.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_shr = sin_r;
            assign w_shl = sin_l;
            assign w_ror = q;
            assign w_rol = q;
        end else begin : g_wn
            assign w_shr = {sin_r, q[WIDTH-1:1]};
            assign w_shl = {q[WIDTH-2:0], sin_l};
            assign w_ror = {q[0], q[WIDTH-1:1]};
            assign w_rol = {q[WIDTH-2:0], q[WIDTH-1]};
        end
    endgenerate

    always_comb begin
        w_next = q;
        case (mode)
            MODE_HOLD: w_next = q;
            MODE_LOAD: w_next = d;
            MODE_SHR:  w_next = w_shr;
            MODE_SHL:  w_next = w_shl;
            MODE_ROR:  w_next = w_ror;
            MODE_ROL:  w_next = w_rol;
            MODE_TGL:  w_next = q ^ d;
            MODE_CLR:  w_next = '0;
            default:   w_next = q;
        endcase
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            usr_bit_cell #(
                .RST_VAL (RESET_VAL[i])
            ) u_cell (
                .clk   (clk),
                .reset (reset),
                .en    (en),
                .d     (w_next[i]),
                .q     (q[i]),
                .q_bar (q_bar[i])
            );
        end
    endgenerate

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign zero   = (q == '0);
endmodule
